button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Multi-channel input conditioner between the raw board push-buttons and the ALU toplevel.
- Each channel passes through a 2-FF synchronizer and then a counter-based debounce FSM.
- Each channel outputs a clean level and a single-cycle press pulse.
- The o_pulse bits drive the first-operand, second-operand and opcode save strobes; the o_level bit of the reset button drives the ALU reset.
- Bit map: 0 = btnL, 1 = btnC, 2 = btnR, 3 = btnU.

Parameters:
- NB_BUTTONS, 4: number of independent channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz). Must be >= 1.
- NB_COUNTER, 20: per-channel counter width. Requires DEBOUNCE_CYCLES <= 2^NB_COUNTER.

Ports:
- i_clock, input, 1: system clock; all logic on its rising edge.
- i_reset, input, 1: reset, synchronous and active-high.
- i_button, input, NB_BUTTONS: raw asynchronous, bouncing button inputs.
- o_level, output, NB_BUTTONS: debounced level per channel, registered.
- o_pulse, output, NB_BUTTONS: one-cycle pulse on each accepted press (0->1), registered.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - Clears both synchronizer stages, all FSMs (to IDLE), all counters, o_level and o_pulse to 0.
  - Reset has priority over every other event, including mid-count.
- Synchronizer: s1 <= i_button; s2 <= s1. The FSM uses s2 only.
- Per-channel FSM, 4 states, fully independent per channel (own state and counter):
  - IDLE (o_level=0): if s2=1, go to WAIT_HIGH with cnt <= 0.
  - WAIT_HIGH (o_level=0):
    - if s2=0, go to IDLE;
    - else if cnt == DEBOUNCE_CYCLES-1, go to HIGH, set o_level <= 1 and o_pulse <= 1;
    - else cnt <= cnt+1.
  - HIGH (o_level=1): if s2=0, go to WAIT_LOW with cnt <= 0.
  - WAIT_LOW (o_level=1):
    - if s2=1, go to HIGH (no pulse);
    - else if cnt == DEBOUNCE_CYCLES-1, go to IDLE, set o_level <= 0;
    - else cnt <= cnt+1.
- o_pulse:
  - Is 0 on every cycle except the single cycle following entry to HIGH.
  - No pulse is generated on release.
- Latency (D = DEBOUNCE_CYCLES, k = first rising edge sampling a stable level on i_button):
  - Press: o_level and o_pulse change after edge k+D+2.
  - Release: o_level changes after edge k+D+2.
- Bounce: any opposite sample in WAIT_HIGH or WAIT_LOW aborts back to the prior stable state; the count restarts from 0 on the next transition. Glitches shorter than D synchronized samples never change o_level.
- A button held high through reset deassertion is treated as a new press: a pulse is issued D+2 edges after the first post-reset sampling edge.
- Simultaneous presses on several channels yield pulses in the same cycle when their timing is identical.
- Counter never wraps: it is bounded by the compare at DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=8, NB_COUNTER=4):
1. Assert i_reset for 3 cycles with i_button=4'b1111. During reset: o_level=0, o_pulse=0. After deassert: o_pulse=4'b1111 for exactly 1 cycle, 10 edges after the first post-reset sampling edge.
2. Raise i_button[0] at edge k and hold 30 cycles. o_pulse[0]=1 only in the cycle after edge k+10; o_level[0]=1 from then on; other bits stay 0.
3. i_button[1] pattern high 3, low 1, high 5, low 2, then high stable from edge m. No pulse or level change during the bounce; single o_pulse[1] after edge m+10.
4. With channel 0 in HIGH, drop i_button[0] for 4 cycles, then high again. o_level[0] stays 1, no pulse. Then drop it stable from edge n: o_level[0]=0 after edge n+10, o_pulse[0] stays 0.
5. Raise i_button[0] and i_button[2] on the same edge. o_pulse=4'b0101 in one identical cycle; o_level=4'b0101 after it.
6. Raise i_button[3]; assert i_reset while its counter=5 (WAIT_HIGH), button still held. Outputs stay 0; after reset release, o_pulse[3] fires 10 edges after the first post-reset sample, not earlier.

Source files
------------

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: a 2-FF synchronizer followed by a
// counter-based debounce FSM per channel, giving a clean level and a press pulse.
module button_debouncer #(
  parameter int NB_BUTTONS      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_COUNTER      = 20
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_BUTTONS-1:0] i_button,
  output logic [NB_BUTTONS-1:0] o_level,
  output logic [NB_BUTTONS-1:0] o_pulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

  logic [NB_BUTTONS-1:0] r_sync1;
  logic [NB_BUTTONS-1:0] r_sync2;

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge, so it must sit at the top of the if-chain.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_channel
    state_t                r_state;
    state_t                w_state_next;
    logic [NB_COUNTER-1:0] r_cnt;
    logic [NB_COUNTER-1:0] w_cnt_next;
    logic                  r_level;
    logic                  r_pulse;
    logic                  w_level_next;
    logic                  w_pulse_next;
    logic                  w_sample;
    logic                  w_done;

    assign w_sample = r_sync2[g];
    assign w_done   = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
        r_level <= w_level_next;
        r_pulse <= w_pulse_next;
      end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
        IDLE: begin
          if (w_sample) begin
            w_state_next = WAIT_HIGH;
            w_cnt_next   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!w_sample)   w_state_next = IDLE;
          else if (w_done) w_state_next = HIGH;
          else             w_cnt_next   = r_cnt + NB_COUNTER'(1);
        end
        HIGH: begin
          if (!w_sample) begin
            w_state_next = WAIT_LOW;
            w_cnt_next   = '0;
          end
        end
        WAIT_LOW: begin
          if (w_sample)    w_state_next = HIGH;
          else if (w_done) w_state_next = IDLE;
          else             w_cnt_next   = r_cnt + NB_COUNTER'(1);
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end

    // Pulse only on an accepted press; a bounce back from WAIT_LOW is silent.
    always_comb begin
      w_level_next = (w_state_next == HIGH) || (w_state_next == WAIT_LOW);
      w_pulse_next = (r_state == WAIT_HIGH) && (w_state_next == HIGH);
    end

    assign o_level[g] = r_level;
    assign o_pulse[g] = r_pulse;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and randomized bench for button_debouncer (D=8), checked against a
// run-length model: a level flips after D+1 consecutive disagreeing samples.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [NB-1:0] i_button = '0;
  logic [NB-1:0] o_level;
  logic [NB-1:0] o_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NB-1:0] m_s1 = '0;
  logic [NB-1:0] m_s2 = '0;
  logic [NB-1:0] m_level = '0;
  logic [NB-1:0] m_pulse = '0;
  int            m_run[NB];

  button_debouncer #(
    .NB_BUTTONS     (NB),
    .DEBOUNCE_CYCLES(D),
    .NB_COUNTER     (4)
  ) dut (
    .i_clock (clk),
    .i_reset (i_reset),
    .i_button(i_button),
    .o_level (o_level),
    .o_pulse (o_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // A channel's level changes once the synchronized input has disagreed with
  // it for D+1 consecutive samples; any agreeing sample restarts the run.
  task automatic model_step(input logic rst, input logic [NB-1:0] btn);
    if (rst) begin
      m_s1 = '0;
      m_s2 = '0;
      m_level = '0;
      m_pulse = '0;
      for (int c = 0; c < NB; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        m_pulse[c] = 1'b0;
        if (m_s2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_level[c] = m_s2[c];
            m_pulse[c] = m_s2[c];
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  endtask

  task automatic tick(input logic rst, input logic [NB-1:0] btn);
    i_reset  = rst;
    i_button = btn;
    @(posedge clk);
    model_step(rst, btn);
    #1;
    check("model_level", o_level, m_level);
    check("model_pulse", o_pulse, m_pulse);
  endtask

  initial begin
    for (int c = 0; c < NB; c++) m_run[c] = 0;

    // 1: reset with all buttons held, then every channel reports a press
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'b1111);
      check("rst_level", o_level, 4'b0000);
      check("rst_pulse", o_pulse, 4'b0000);
    end
    for (int i = 0; i <= 14; i++) begin
      tick(1'b0, 4'b1111);
      check("t1_pulse", o_pulse, (i == 10) ? 4'b1111 : 4'b0000);
      check("t1_level", o_level, (i >= 10) ? 4'b1111 : 4'b0000);
    end
    for (int i = 0; i <= 14; i++) tick(1'b0, 4'b0000);
    check("t1_release", o_level, 4'b0000);

    // 2: single clean press on channel 0
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 4'b0001);
      check("t2_pulse", o_pulse, (i == 10) ? 4'b0001 : 4'b0000);
      check("t2_level", o_level, (i >= 10) ? 4'b0001 : 4'b0000);
    end

    // 3: bouncing press on channel 1, then stable
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, (i < 3 || (i >= 4 && i < 9)) ? 4'b0011 : 4'b0001);
      check("t3_bounce_level", o_level, 4'b0001);
      check("t3_bounce_pulse", o_pulse, 4'b0000);
    end
    for (int i = 0; i <= 14; i++) begin
      tick(1'b0, 4'b0011);
      check("t3_pulse", o_pulse, (i == 10) ? 4'b0010 : 4'b0000);
    end

    // 4: short drop on channel 0 is ignored, a long one releases silently
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'b0010);
      check("t4_glitch_level", o_level, 4'b0011);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b0011);
    check("t4_hold_level", o_level, 4'b0011);
    for (int i = 0; i <= 14; i++) begin
      tick(1'b0, 4'b0010);
      check("t4_rel_level", o_level, (i >= 10) ? 4'b0010 : 4'b0011);
      check("t4_rel_pulse", o_pulse, 4'b0000);
    end

    // 5: simultaneous presses on channels 0 and 2
    for (int i = 0; i <= 14; i++) tick(1'b0, 4'b0000);
    check("t5_idle", o_level, 4'b0000);
    for (int i = 0; i <= 14; i++) begin
      tick(1'b0, 4'b0101);
      check("t5_pulse", o_pulse, (i == 10) ? 4'b0101 : 4'b0000);
    end
    check("t5_level", o_level, 4'b0101);

    // 6: reset mid-count on channel 3 restarts the whole debounce
    for (int i = 0; i <= 14; i++) tick(1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'b1000);
      check("t6_count_pulse", o_pulse, 4'b0000);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 4'b1000);
      check("t6_rst_level", o_level, 4'b0000);
      check("t6_rst_pulse", o_pulse, 4'b0000);
    end
    for (int i = 0; i <= 14; i++) begin
      tick(1'b0, 4'b1000);
      check("t6_pulse", o_pulse, (i == 10) ? 4'b1000 : 4'b0000);
    end

    // Random bounce patterns with occasional resets, checked against the model
    for (int s = 0; s < 60; s++) begin
      logic [NB-1:0] btn;
      int            hold;
      btn  = NB'($urandom);
      hold = (($urandom_range(0, 3) == 0) ? 12 : 1) + int'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) begin
        for (int r = 0; r < int'($urandom_range(1, 2)); r++) tick(1'b1, btn);
      end
      for (int h = 0; h < hold; h++) tick(1'b0, btn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
